index_stream_gen: RTL and testbench
===================================

# index_stream_gen

Upstream source for the index decoder stage: generates a pseudo-random stream of 3-bit indices with a one-cycle valid strobe and paces it by a fixed gap. The stream stops when a programmed count is reached or the downstream decoder asserts `done`. It replaces hand-fed index data so decode and LED readout can run from a single `start` pulse.

## Interface
Parameters:
- `SEED`, 8'h01, initial LFSR value; 8'h00 is illegal and is loaded as 8'h01.
- `COUNT`, 16, indices emitted per run; legal range 1..255.
- `GAP`, 0, idle cycles between consecutive valid strobes; legal range 0..15.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level sampled on posedge; starts a run from IDLE or FINISH, ignored otherwise.
- `done` in 1: downstream completion/abort; sampled on posedge.
- `index_reg` out 3: current index; meaningful only while `index_reg_valid` is 1.
- `index_reg_valid` out 1: one-cycle strobe per emitted index.
- `busy` out 1: high in EMIT and WAIT.
- `finished` out 1: high in FINISH.
- `emitted_count` out 8: number of valid strobes issued in the current or last run.

## Operation
- All outputs are registered.
- LFSR (8 bit, Fibonacci, shifts left):
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Emitted index = lfsr[2:0] of the value current at emission.
  - The LFSR advances once per emission, after the value is used.
- States:
  - IDLE, from reset: no emission.
  - EMIT: `index_reg_valid`=1 for exactly this cycle; `emitted_count` increments.
  - WAIT: GAP-cycle counter.
  - FINISH: run over, outputs hold.
- Transitions:
  - IDLE/FINISH with `start`=1 → EMIT. The LFSR reloads SEED (0 → 8'h01) and `emitted_count` clears to 0 on the same edge.
  - EMIT → FINISH if this emission makes `emitted_count`==COUNT, or `done`=1.
  - EMIT → EMIT if GAP=0, otherwise EMIT → WAIT.
  - WAIT → EMIT after GAP cycles in WAIT. WAIT → FINISH immediately if `done`=1.
  - FINISH holds until `start`=1. `done` is ignored in IDLE and FINISH.
- `done` has priority over count and gap: once sampled high in EMIT or WAIT, no further strobes are issued.
- `start` while busy is ignored; it does not restart the run.
- `index_reg` holds its last emitted value when not valid.

## Timing
- Reset values: state=IDLE, `index_reg`=0, `index_reg_valid`=0, `busy`=0, `finished`=0, `emitted_count`=0, lfsr=SEED (0 → 8'h01).
- Reset is asynchronous: asserting `rst` mid-run forces every output to its reset value immediately, with no further strobes. After release the block waits in IDLE for `start`.
- Start latency: `start` sampled at edge N → first strobe visible in cycle N+1 (after edge N).
- Strobe period is GAP+1 cycles.
- Run length with no `done`: first strobe to `finished`=1 is (COUNT−1)·(GAP+1)+1 cycles.
- `done` sampled high at edge M → `index_reg_valid`=0 from edge M onward. A strobe already presented in the cycle before edge M counts as emitted.
- `done` and the final count in the same EMIT cycle → FINISH; counted once, no extra strobe.
- `emitted_count` never exceeds COUNT and never wraps; COUNT ≤ 255.
- `busy` and `finished` are mutually exclusive; both are 0 in IDLE.

## Test plan
- Reset then `start` pulse, SEED=8'h01, GAP=0, COUNT=6:
  - strobes on 6 consecutive cycles with `index_reg`=1,2,4,0,1,3 (LFSR 01,02,04,08,11,23);
  - then `finished`=1 and `emitted_count`=6.
- GAP=3, COUNT=3: strobes exactly 4 cycles apart; `busy` high from first strobe through the cycle before `finished`; `finished` asserts 1 cycle after the 3rd strobe.
- `done` driven high during the 2nd WAIT period (GAP=2, COUNT=10): no 3rd strobe, `emitted_count`=2, `finished`=1 next cycle.
- Async `rst` pulsed mid-run, between clock edges: all outputs reach reset values before the next edge. A new `start` replays the sequence from 1,2,4.
- `start` held high for the whole run: ignored while busy. In FINISH it restarts on the next edge with a reloaded seed and `emitted_count` cleared to 0.
- SEED=8'h00: behaves identically to SEED=8'h01 (first index 1).

Source files
------------

// File: rtl/index_stream_gen.sv
// index_stream_gen
//   Generates a paced stream of pseudo-random 3-bit indices for the index decoder.
//   A run starts on `start` in IDLE or FINISH. It emits COUNT indices, each with
//   a one-cycle valid strobe, and leaves GAP idle cycles between strobes. The run
//   ends early when the downstream `done` is sampled high.
//
// Ports
//   clk             in   single clock, posedge
//   rst             in   asynchronous active-high reset
//   start           in   begin a run (honoured in IDLE / FINISH only)
//   done            in   downstream completion / abort (honoured in EMIT / WAIT)
//   index_reg       out  current index, held between strobes
//   index_reg_valid out  one-cycle strobe per emitted index
//   busy            out  high in EMIT and WAIT
//   finished        out  high in FINISH
//   emitted_count   out  strobes issued in the current or last run
module index_stream_gen #(
    parameter logic [7:0]  SEED  = 8'h01,
    parameter int unsigned COUNT = 16,
    parameter int unsigned GAP   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    output logic [2:0] index_reg,
    output logic       index_reg_valid,
    output logic       busy,
    output logic       finished,
    output logic [7:0] emitted_count
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
    localparam logic [7:0] SeedEff   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] CountLast = 8'(COUNT);
    localparam logic [3:0] GapInit   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StEmit, StWait, StFinish} state_t;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, busy_q, fin_q;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle, StFinish: begin
                if (start) begin
                    state_d = StEmit;
                    lfsr_d  = SeedEff;
                    cnt_d   = 8'd0;
                end
            end
            StEmit: begin
                // The strobe shown this cycle is counted and the LFSR steps at its end.
                lfsr_d = lfsr_next(lfsr_q);
                cnt_d  = cnt_q + 8'd1;
                if (done || cnt_d == CountLast) begin
                    state_d = StFinish;
                end else if (GAP == 0) begin
                    state_d = StEmit;
                end else begin
                    state_d = StWait;
                    gap_d   = GapInit;
                end
            end
            StWait: begin
                if (done) begin
                    state_d = StFinish;
                end else if (gap_q == 4'd0) begin
                    state_d = StEmit;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are registered, so the index is loaded on the edge entering EMIT.
        if (state_d == StEmit) begin
            idx_d = lfsr_d[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            gap_q   <= 4'd0;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= (state_d == StEmit);
            busy_q  <= (state_d == StEmit) || (state_d == StWait);
            fin_q   <= (state_d == StFinish);
        end
    end

    assign index_reg       = idx_q;
    assign index_reg_valid = valid_q;
    assign busy            = busy_q;
    assign finished        = fin_q;
    assign emitted_count   = cnt_q;

endmodule

// File: tb/tb_index_stream_gen.sv
// Self-checking bench for index_stream_gen. Four instances with different SEED/COUNT/GAP
// share clk, rst, start and done. A run-level reference model tracks, per instance, how
// far into the run we are and predicts every output, which is compared on each falling edge.
module tb_index_stream_gen;

    logic clk;
    logic rst;
    logic start;
    logic done;

    logic [3:0][2:0] idx;
    logic [3:0]      vld;
    logic [3:0]      bsy;
    logic [3:0]      fin;
    logic [3:0][7:0] cnt;

    int n_checks;
    int n_fail;

    // Model: per-instance configuration and run progress.
    int         gp[4];
    int         cn[4];
    logic [7:0] sd[4];
    int         m_act[4];
    int         m_fin[4];
    int         m_t[4];
    int         m_k[4];
    int         m_idx[4];
    logic [7:0] m_lfsr[4];

    index_stream_gen #(.SEED(8'h01), .COUNT(6), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .index_reg(idx[0]), .index_reg_valid(vld[0]), .busy(bsy[0]),
        .finished(fin[0]), .emitted_count(cnt[0])
    );
    index_stream_gen #(.SEED(8'hA5), .COUNT(3), .GAP(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .index_reg(idx[1]), .index_reg_valid(vld[1]), .busy(bsy[1]),
        .finished(fin[1]), .emitted_count(cnt[1])
    );
    index_stream_gen #(.SEED(8'h01), .COUNT(10), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .index_reg(idx[2]), .index_reg_valid(vld[2]), .busy(bsy[2]),
        .finished(fin[2]), .emitted_count(cnt[2])
    );
    index_stream_gen #(.SEED(8'h00), .COUNT(5), .GAP(1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .index_reg(idx[3]), .index_reg_valid(vld[3]), .busy(bsy[3]),
        .finished(fin[3]), .emitted_count(cnt[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0;
            m_fin[i] = 0;
            m_t[i]   = 0;
            m_k[i]   = 0;
            m_idx[i] = 0;
        end
    endtask

    // Advance the model across one rising edge with the inputs sampled there.
    task automatic model_step(input logic st, input logic dn);
        for (int i = 0; i < 4; i++) begin
            if (m_act[i] == 0) begin
                if (st) begin
                    m_act[i]  = 1;
                    m_fin[i]  = 0;
                    m_t[i]    = 0;
                    m_k[i]    = 0;
                    m_lfsr[i] = (sd[i] == 8'h00) ? 8'h01 : sd[i];
                end
            end else begin
                if (m_t[i] % (gp[i] + 1) == 0) begin
                    m_k[i]++;
                    m_lfsr[i] = lfsr_step(m_lfsr[i]);
                end
                if (dn || m_k[i] == cn[i]) begin
                    m_act[i] = 0;
                    m_fin[i] = 1;
                end else begin
                    m_t[i]++;
                end
            end
            if (m_act[i] != 0 && m_t[i] % (gp[i] + 1) == 0) m_idx[i] = int'(m_lfsr[i][2:0]);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            int strobe;
            strobe = (m_act[i] != 0 && m_t[i] % (gp[i] + 1) == 0) ? 1 : 0;
            check_eq($sformatf("u%0d.valid", i), int'(vld[i]), strobe);
            check_eq($sformatf("u%0d.index", i), int'(idx[i]), m_idx[i]);
            check_eq($sformatf("u%0d.busy", i), int'(bsy[i]), m_act[i]);
            check_eq($sformatf("u%0d.finished", i), int'(fin[i]), m_fin[i]);
            check_eq($sformatf("u%0d.count", i), int'(cnt[i]), m_k[i]);
        end
    endtask

    task automatic cycle(input logic st, input logic dn);
        start = st;
        done  = dn;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(st, dn);
        @(negedge clk);
        compare_all();
    endtask

    // Assert reset between edges and check outputs before the next rising edge.
    task automatic mid_reset();
        start = 1'b0;
        done  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        cycle(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic hold_start;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        gp = '{0, 3, 2, 1};
        cn = '{6, 3, 10, 5};
        sd = '{8'h01, 8'hA5, 8'h01, 8'h00};
        rst   = 1'b1;
        start = 1'b0;
        done  = 1'b0;
        model_reset();
        #1;
        compare_all();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 1'b0);

        // Full runs with no done.
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 40; c++) cycle(1'b0, 1'b0);

        // done lands during the second wait of the GAP=2 instance.
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0);

        // Reset mid-run, then replay.
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0);
        mid_reset();
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0);

        // start held high: ignored while busy, restarts from FINISH.
        for (int c = 0; c < 50; c++) cycle(1'b1, 1'b0);

        // Randomised traffic.
        hold_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 49) == 0) hold_start = ~hold_start;
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                cycle(hold_start | ($urandom_range(0, 7) == 0),
                      $urandom_range(0, 11) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
